// File: rtl/softmax_row_packer.sv
// Packs a serial 16-bit score stream into N-lane rows, padding short rows with PAD_VAL.
// One-cycle latency from the closing beat to valid_out; in_ready equals en, and downstream cannot stall.
module softmax_row_packer #(
  parameter int          N       = 8,
  parameter logic [15:0] PAD_VAL = 16'h8000,
  parameter int          LW      = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  input  logic            in_last,
  output logic            valid_out,
  output logic [N*16-1:0] out_flat,
  output logic [LW-1:0]   out_len
);

  localparam int CW = $clog2(N);

  logic [N-1:0][15:0] row_buf;
  logic [N-1:0][15:0] close_row;
  logic [CW-1:0]      cnt;
  logic               closing;

  assign in_ready = en;
  assign closing  = in_last | (cnt == CW'(N-1));

  // Lanes at and above cnt are always PAD_VAL in row_buf, so only lane cnt needs patching.
  always_comb begin
    close_row      = row_buf;
    close_row[cnt] = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      row_buf   <= {N{PAD_VAL}};
      valid_out <= 1'b0;
      out_len   <= '0;
      out_flat  <= {N{PAD_VAL}};
    end else if (en) begin
      valid_out <= 1'b0;
      if (in_valid) begin
        if (closing) begin
          out_flat  <= close_row;
          out_len   <= LW'(cnt) + LW'(1);
          valid_out <= 1'b1;
          cnt       <= '0;
          row_buf   <= {N{PAD_VAL}};
        end else begin
          row_buf[cnt] <= in_data;
          cnt          <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_packer.sv
// Directed bench for softmax_row_packer: row-queue reference model checked every cycle,
// plus literal expectations on each captured output row.
module tb_softmax_row_packer;

  localparam int          N   = 8;
  localparam int          LW  = $clog2(N+1);
  localparam int          W   = N*16;
  localparam logic [15:0] PAD = 16'h8000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          valid_out;
  logic [W-1:0]  out_flat;
  logic [LW-1:0] out_len;

  int total = 0;
  int bad = 0;

  softmax_row_packer #(.N(N), .PAD_VAL(PAD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .valid_out(valid_out), .out_flat(out_flat), .out_len(out_len)
  );

  always #5 clk = ~clk;

  // Reference model: the row under assembly is a plain queue of accepted scores.
  logic [15:0]   row_q[$];
  logic          exp_vld;
  logic [W-1:0]  exp_flat;
  logic [LW-1:0] exp_len;
  logic          loaded_at_edge;

  function automatic logic [W-1:0] pad_row(input logic [15:0] elems[$]);
    logic [W-1:0] f;
    for (int i = 0; i < N; i++) f[i*16 +: 16] = (i < elems.size()) ? elems[i] : PAD;
    return f;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q.delete();
      exp_vld        = 1'b0;
      exp_len        = '0;
      exp_flat       = {N{PAD}};
      loaded_at_edge = 1'b0;
    end else if (en) begin
      exp_vld        = 1'b0;
      loaded_at_edge = 1'b0;
      if (in_valid) begin
        row_q.push_back(in_data);
        if (in_last || row_q.size() == N) begin
          exp_flat       = pad_row(row_q);
          exp_len        = LW'(row_q.size());
          exp_vld        = 1'b1;
          loaded_at_edge = 1'b1;
          row_q.delete();
        end
      end
    end else begin
      loaded_at_edge = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("in_ready", W'(in_ready), W'(en));
    chk("valid_out", W'(valid_out), W'(exp_vld));
    chk("out_len", W'(out_len), W'(exp_len));
    chk("out_flat", out_flat, exp_flat);
  end

  // Rows as they appear at the output, one entry per freshly loaded pulse.
  logic [W-1:0]  cap_flat[$];
  logic [LW-1:0] cap_len[$];

  always @(negedge clk) begin
    if (rst && valid_out && loaded_at_edge) begin
      cap_flat.push_back(out_flat);
      cap_len.push_back(out_len);
    end
  end

  function automatic logic [W-1:0] lanes8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic expect_row(input string name, input logic [W-1:0] flat, input int len);
    total++;
    if (cap_flat.size() == 0) begin
      bad++;
      $display("FAIL %s: no row captured, expected len %0d", name, len);
    end else begin
      logic [W-1:0]  f;
      logic [LW-1:0] l;
      f = cap_flat.pop_front();
      l = cap_len.pop_front();
      if (f !== flat || l !== LW'(len)) begin
        bad++;
        $display("FAIL %s: got len %0d flat %h expected len %0d flat %h", name, l, f, len, flat);
      end
    end
  endtask

  task automatic expect_no_more(input string name);
    total++;
    if (cap_flat.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d extra rows captured, expected 0", name, cap_flat.size());
      cap_flat.delete();
      cap_len.delete();
    end
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    idle(2);
    chk("reset valid_out", W'(valid_out), W'(0));
    chk("reset out_flat", out_flat, {N{16'h8000}});
    rst = 1'b1;
    idle(1);

    // Full row
    for (int i = 1; i <= 8; i++) beat(16'(i), i == 8);
    idle(1);
    expect_row("full row", lanes8(1, 2, 3, 4, 5, 6, 7, 8), 8);

    // Short row
    beat(16'h0A00, 1'b0); beat(16'h0B00, 1'b0); beat(16'h0C00, 1'b1);
    idle(2);
    expect_row("short row", lanes8(16'h0A00, 16'h0B00, 16'h0C00, PAD, PAD, PAD, PAD, PAD), 3);

    // Split row
    for (int i = 1; i <= 10; i++) beat(16'(i), i == 10);
    idle(1);
    expect_row("split first", lanes8(1, 2, 3, 4, 5, 6, 7, 8), 8);
    expect_row("split second", lanes8(9, 10, PAD, PAD, PAD, PAD, PAD, PAD), 2);

    // Back-to-back length-1 rows
    beat(5, 1'b1); beat(6, 1'b1); beat(7, 1'b1);
    idle(1);
    expect_row("b2b 5", lanes8(5, PAD, PAD, PAD, PAD, PAD, PAD, PAD), 1);
    expect_row("b2b 6", lanes8(6, PAD, PAD, PAD, PAD, PAD, PAD, PAD), 1);
    expect_row("b2b 7", lanes8(7, PAD, PAD, PAD, PAD, PAD, PAD, PAD), 1);

    // Enable stall mid-row with in_valid held high
    beat(16'h0011, 1'b0); beat(16'h0012, 1'b0);
    en = 1'b0; in_valid = 1'b1; in_data = 16'h0013; in_last = 1'b1;
    idle(3);
    chk("stall in_ready", W'(in_ready), W'(0));
    en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    // Freeze immediately after a close: valid_out must stay high while disabled.
    en = 1'b0;
    idle(2);
    chk("held valid_out", W'(valid_out), W'(1));
    en = 1'b1;
    idle(1);
    expect_row("stall row", lanes8(16'h0011, 16'h0012, 16'h0013, PAD, PAD, PAD, PAD, PAD), 3);

    // Reset mid-row
    for (int i = 1; i <= 5; i++) beat(16'(16'h0100 + i), 1'b0);
    rst = 1'b0;
    #1;
    chk("async reset valid_out", W'(valid_out), W'(0));
    chk("async reset out_len", W'(out_len), W'(0));
    chk("async reset out_flat", out_flat, {N{16'h8000}});
    idle(2);
    rst = 1'b1;
    idle(1);
    beat(16'h0AAA, 1'b0); beat(16'h0BBB, 1'b1);
    idle(1);
    expect_row("after reset", lanes8(16'h0AAA, 16'h0BBB, PAD, PAD, PAD, PAD, PAD, PAD), 2);

    idle(3);
    expect_no_more("no spurious rows");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
